// File: rtl/reg_writeback_unit_pkg.sv
// Shared register-file definitions for the writeback slice.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: architectural register count, register address width,
// default result width and the hard-wired zero register address.
package reg_writeback_unit_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NREG_DEF   = 16;
  localparam int DATA_W_DEF = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/reg_writeback_unit_fifo.sv
// wb_fifo: synchronous result FIFO with two push ports and one pop port.
// Latency: an entry pushed at edge N is visible on o_head after edge N.
// Backpressure: none internally; the caller must keep pushes within free space.
// Ports: i_push_a/i_dat_a is written ahead of i_push_b/i_dat_b when both are
// set; i_pop retires o_head; o_count/o_empty report occupancy.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push_a,
  input  logic [W-1:0]             i_dat_a,
  input  logic                     i_push_b,
  input  logic [W-1:0]             i_dat_b,
  input  logic                     i_pop,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic [W-1:0]             o_head
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wp;
  logic [PTR_W-1:0] r_rp;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_wp_b;

  // Port B lands in the slot after port A only when A is also pushing.
  assign w_wp_b = r_wp + PTR_W'(i_push_a);

  always_ff @(posedge clk) begin
    if (i_push_a) r_mem[r_wp]   <= i_dat_a;
    if (i_push_b) r_mem[w_wp_b] <= i_dat_b;
  end

  // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      r_wp    <= r_wp + PTR_W'(i_push_a) + PTR_W'(i_push_b);
      r_rp    <= r_rp + PTR_W'(i_pop);
      r_count <= r_count + CNT_W'(i_push_a) + CNT_W'(i_push_b) - CNT_W'(i_pop);
    end
  end

  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rp];
endmodule

// File: rtl/reg_writeback_unit.sv
// reg_writeback_unit: merges ALU and load results into one register-bank
// write per cycle and keeps the pending-write scoreboard for decode.
// Latency: 2 cycles accept-to-wb_en; 1 cycle when WB_BYPASS_EN is defined and
// the FIFO is empty.
// Backpressure: both sources ready only while the FIFO has >= 2 free entries.
// Ports: i_alu_* / i_mem_* result inputs with o_*_ready; i_iss_* reserves a
// destination; i_chk_rs/i_chk_rt -> o_busy_rs/o_busy_rt (combinational);
// o_pending scoreboard; o_wb_en/o_wb_rd/o_wb_data registered bank write;
// o_err_rd sticky out-of-range destination flag.
// Optional macro WB_BYPASS_EN: a result arriving at an empty FIFO goes
// straight to the output registers.
module reg_writeback_unit
  import reg_writeback_unit_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG   = NREG_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_alu_valid,
  input  logic [REG_ADDR_W-1:0] i_alu_rd,
  input  logic [DATA_W-1:0]     i_alu_data,
  output logic                  o_alu_ready,
  input  logic                  i_mem_valid,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  input  logic [DATA_W-1:0]     i_mem_data,
  output logic                  o_mem_ready,
  input  logic                  i_iss_valid,
  input  logic [REG_ADDR_W-1:0] i_iss_rd,
  input  logic [REG_ADDR_W-1:0] i_chk_rs,
  input  logic [REG_ADDR_W-1:0] i_chk_rt,
  output logic                  o_busy_rs,
  output logic                  o_busy_rt,
  output logic [NREG-1:0]       o_pending,
  output logic                  o_wb_en,
  output logic [REG_ADDR_W-1:0] o_wb_rd,
  output logic [DATA_W-1:0]     o_wb_data,
  output logic                  o_err_rd
);
  localparam int ENT_W = REG_ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // One-hot of a register address; r0 and out-of-range addresses map to
  // zero so they can never be reserved, cleared or reported busy.
  function automatic logic [NREG-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    rd_onehot = '0;
    for (int i = 1; i < NREG; i++) begin
      if (rd == REG_ADDR_W'(i)) rd_onehot[i] = 1'b1;
    end
  endfunction

  logic                  r_wb_en;
  logic [REG_ADDR_W-1:0] r_wb_rd;
  logic [DATA_W-1:0]     r_wb_data;
  logic [NREG-1:0]       r_pending;
  logic                  r_err_rd;

  logic [CNT_W-1:0] w_count;
  logic             w_empty;
  logic [ENT_W-1:0] w_head;
  logic             w_ready;
  logic             w_alu_acc, w_mem_acc;
  logic             w_alu_oob, w_mem_oob;
  logic             w_alu_ok, w_mem_ok;
  logic             w_byp_alu, w_byp_mem;
  logic             w_push_a, w_push_b, w_pop;
  logic [NREG-1:0]  w_pending_nxt;

  assign w_ready   = (CNT_W'(DEPTH) - w_count) >= CNT_W'(2);
  assign w_alu_acc = i_alu_valid && w_ready;
  assign w_mem_acc = i_mem_valid && w_ready;
  assign w_alu_oob = 32'(i_alu_rd) >= NREG;
  assign w_mem_oob = 32'(i_mem_rd) >= NREG;
  // Only results with a real destination are ever written to the bank.
  assign w_alu_ok  = w_alu_acc && !w_alu_oob && (i_alu_rd != REG_ZERO);
  assign w_mem_ok  = w_mem_acc && !w_mem_oob && (i_mem_rd != REG_ZERO);

`ifdef WB_BYPASS_EN
  // Bypass only into an empty FIFO so older entries are never overtaken;
  // with two writable results the ALU one bypasses and the load queues.
  assign w_byp_alu = w_empty && w_alu_ok;
  assign w_byp_mem = w_empty && w_mem_ok && !w_alu_ok;
`else
  assign w_byp_alu = 1'b0;
  assign w_byp_mem = 1'b0;
`endif

  assign w_push_a = w_alu_ok && !w_byp_alu;
  assign w_push_b = w_mem_ok && !w_byp_mem;
  assign w_pop    = !w_empty;

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_push_a (w_push_a),
    .i_dat_a  ({i_alu_rd, i_alu_data}),
    .i_push_b (w_push_b),
    .i_dat_b  ({i_mem_rd, i_mem_data}),
    .i_pop    (w_pop),
    .o_count  (w_count),
    .o_empty  (w_empty),
    .o_head   (w_head)
  );

  // Pop and bypass are mutually exclusive: pop needs a non-empty FIFO,
  // bypass needs an empty one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_en   <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
    end else if (w_pop) begin
      r_wb_en              <= 1'b1;
      {r_wb_rd, r_wb_data} <= w_head;
    end else if (w_byp_alu) begin
      r_wb_en   <= 1'b1;
      r_wb_rd   <= i_alu_rd;
      r_wb_data <= i_alu_data;
    end else if (w_byp_mem) begin
      r_wb_en   <= 1'b1;
      r_wb_rd   <= i_mem_rd;
      r_wb_data <= i_mem_data;
    end else begin
      r_wb_en   <= 1'b0;
    end
  end

  // Clear lands on the same edge the bank stores the data; a reissue of the
  // same register on that edge wins because the set is OR-ed in last.
  assign w_pending_nxt = (r_pending & ~(r_wb_en ? rd_onehot(r_wb_rd) : '0))
                       | (i_iss_valid ? rd_onehot(i_iss_rd) : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_err_rd  <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      if ((w_alu_acc && w_alu_oob) || (w_mem_acc && w_mem_oob)) r_err_rd <= 1'b1;
    end
  end

  assign o_alu_ready = w_ready;
  assign o_mem_ready = w_ready;
  assign o_busy_rs   = |(r_pending & rd_onehot(i_chk_rs));
  assign o_busy_rt   = |(r_pending & rd_onehot(i_chk_rt));
  assign o_pending   = r_pending;
  assign o_wb_en     = r_wb_en;
  assign o_wb_rd     = r_wb_rd;
  assign o_wb_data   = r_wb_data;
  assign o_err_rd    = r_err_rd;
endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed bench for reg_writeback_unit (DEPTH=4, DATA_W=32, NREG=16).
// Inputs change and outputs are sampled 1 ns after the rising edge.
// Honours WB_BYPASS_EN for the latency and ready-pattern expectations.
module tb_reg_writeback_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid, iss_valid;
  logic [4:0]  alu_rd, mem_rd, iss_rd, chk_rs, chk_rt;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, busy_rs, busy_rt;
  logic [15:0] pending;
  logic        wb_en, err_rd;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

`ifdef WB_BYPASS_EN
  localparam int         LAT      = 1;
  localparam logic [5:0] BP_PAT   = 6'b010111;
  localparam int         FILL_CNT = 2;
`else
  localparam int         LAT      = 2;
  localparam logic [5:0] BP_PAT   = 6'b101011;
  localparam int         FILL_CNT = 3;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic        mon_on = 1'b0;
  logic [36:0] got_q[$];
  logic [36:0] exp_q[$];

  reg_writeback_unit #(.DEPTH(4), .DATA_W(32), .NREG(16)) u_dut (
    .clk(clk), .rst(rst),
    .i_alu_valid(alu_valid), .i_alu_rd(alu_rd), .i_alu_data(alu_data), .o_alu_ready(alu_ready),
    .i_mem_valid(mem_valid), .i_mem_rd(mem_rd), .i_mem_data(mem_data), .o_mem_ready(mem_ready),
    .i_iss_valid(iss_valid), .i_iss_rd(iss_rd), .i_chk_rs(chk_rs), .i_chk_rt(chk_rt),
    .o_busy_rs(busy_rs), .o_busy_rt(busy_rt), .o_pending(pending),
    .o_wb_en(wb_en), .o_wb_rd(wb_rd), .o_wb_data(wb_data), .o_err_rd(err_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (mon_on && wb_en) got_q.push_back({wb_rd, wb_data});
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; mem_valid = 1'b0; iss_valid = 1'b0;
  endtask

  initial begin
    logic [5:0] bp_pat;
    logic       seen;
    int         n;
    bp_pat = BP_PAT;
    rst = 1'b1;
    idle_inputs();
    alu_rd = '0; mem_rd = '0; iss_rd = '0; chk_rs = '0; chk_rt = '0;
    alu_data = '0; mem_data = '0;

    // Reset state
    step(); step();
    check_eq("rst_wb_en", wb_en, 0);
    check_eq("rst_wb_rd", wb_rd, 0);
    check_eq("rst_wb_data", wb_data, 0);
    check_eq("rst_pending", pending, 0);
    check_eq("rst_err", err_rd, 0);
    check_eq("rst_ready", alu_ready, 1);
    rst = 1'b0;
    step();

    // Single ALU result r5 = DEADBEEF
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1 check_eq("single_ready", alu_ready, 1);
    step();
    idle_inputs();
    for (int k = 1; k < LAT; k++) begin check_eq("single_early", wb_en, 0); step(); end
    check_eq("single_en", wb_en, 1);
    check_eq("single_rd", wb_rd, 5);
    check_eq("single_data", wb_data, 32'hDEADBEEF);
    step();
    check_eq("single_after", wb_en, 0);

    // Dual accept: r3=0x11 then r7=0x22
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h22;
    step();
    idle_inputs();
    for (int k = 1; k < LAT; k++) step();
    check_eq("dual_first", {wb_en, wb_rd, wb_data}, {1'b1, 5'd3, 32'h11});
    step();
    check_eq("dual_second", {wb_en, wb_rd, wb_data}, {1'b1, 5'd7, 32'h22});
    step();
    check_eq("dual_after", wb_en, 0);
    step();

    // Backpressure: both sources valid for 6 cycles
    mon_on = 1'b1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      alu_valid = 1'b1; alu_rd = 5'(1 + n); alu_data = 32'hA000_0000 + 32'(n);
      mem_valid = 1'b1; mem_rd = 5'(8 + n); mem_data = 32'hB000_0000 + 32'(n);
      #1;
      check_eq($sformatf("bp_ready_c%0d", c), {alu_ready, mem_ready}, {bp_pat[c], bp_pat[c]});
      check_eq($sformatf("bp_cnt_c%0d", c), (u_dut.w_count <= 4), 1);
      if (bp_pat[c]) begin
        exp_q.push_back({5'(1 + n), 32'hA000_0000 + 32'(n)});
        exp_q.push_back({5'(8 + n), 32'hB000_0000 + 32'(n)});
        n++;
      end
      step();
    end
    idle_inputs();
    for (int k = 0; k < 8; k++) step();
    mon_on = 1'b0;
    check_eq("bp_nwrites", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check_eq($sformatf("bp_write%0d", i), (i < got_q.size()) ? got_q[i] : 37'hx, exp_q[i]);

    // Scoreboard
    iss_valid = 1'b1; iss_rd = 5'd9; chk_rs = 5'd9; chk_rt = 5'd20;
    #1 check_eq("sb_busy_before", busy_rs, 0);
    step();
    idle_inputs();
    #1;
    check_eq("sb_pending_set", pending, 16'h0200);
    check_eq("sb_busy_rs", busy_rs, 1);
    check_eq("sb_busy_rt_oob", busy_rt, 0);
    chk_rt = 5'd9;
    #1 check_eq("sb_busy_rt", busy_rt, 1);
    step();
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99;
    step();
    idle_inputs();
    for (int k = 1; k < LAT; k++) begin check_eq("sb_hold", pending[9], 1); step(); end
    check_eq("sb_wb", {wb_en, wb_rd, wb_data}, {1'b1, 5'd9, 32'h99});
    check_eq("sb_busy_at_wb", busy_rs, 1);
    step();
    check_eq("sb_cleared", pending, 0);
    check_eq("sb_busy_cleared", busy_rs, 0);
    // Reissue r9 on the clearing edge
    iss_valid = 1'b1; iss_rd = 5'd9;
    step();
    iss_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h9A;
    step();
    idle_inputs();
    for (int k = 1; k < LAT; k++) step();
    check_eq("sb_wb2", {wb_en, wb_rd}, {1'b1, 5'd9});
    iss_valid = 1'b1; iss_rd = 5'd9;
    step();
    idle_inputs();
    check_eq("sb_reissue_wins", pending, 16'h0200);

    // Drops: ALU r0, then MEM r20
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
    step();
    idle_inputs();
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin seen |= wb_en; step(); end
    check_eq("drop_r0_no_write", seen, 0);
    check_eq("drop_r0_err", err_rd, 0);
    mem_valid = 1'b1; mem_rd = 5'd20; mem_data = 32'h66;
    step();
    idle_inputs();
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin seen |= wb_en; step(); end
    check_eq("drop_oob_no_write", seen, 0);
    check_eq("drop_oob_err", err_rd, 1);
    step(); step(); step();
    check_eq("drop_err_sticky", err_rd, 1);
    check_eq("drop_pending_kept", pending, 16'h0200);

    // Reset mid-stream with the FIFO partly full
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hC1;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'hC2;
    iss_valid = 1'b1; iss_rd = 5'd12;
    step();
    iss_valid = 1'b0;
    alu_rd = 5'd3; alu_data = 32'hC3;
    mem_rd = 5'd4; mem_data = 32'hC4;
    step();
    idle_inputs();
    check_eq("mid_fill_cnt", u_dut.w_count, FILL_CNT);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_wb_en", wb_en, 0);
    check_eq("mid_rst_pending", pending, 0);
    check_eq("mid_rst_cnt", u_dut.w_count, 0);
    check_eq("mid_rst_err", err_rd, 0);
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin step(); seen |= wb_en; end
    check_eq("mid_rst_no_writes", seen, 0);
    check_eq("mid_rst_ready", alu_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
